// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_EN   = 3'd1,
        ACT_BR   = 3'd2,
        ACT_LOAD = 3'd3,
        ACT_CALL = 3'd4,
        ACT_RET  = 3'd5
    } act_t;

    // Count must represent 0..depth inclusive.
    function automatic int unsigned ras_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_seq_unit_ret_addr_stack.sv
// Circular return-address LIFO; a push while full overwrites the oldest entry.
module ret_addr_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top_c,
    output logic [ras_cnt_w(DEPTH)-1:0]  cnt,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = ras_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] wp_inc;
    logic [PTR_W-1:0] wp_dec;
    logic [PTR_W-1:0] wp_d;
    logic [CNT_W-1:0] cnt_d;
    logic             do_pop;

    assign wp_inc = (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + PTR_W'(1);
    assign wp_dec = (wp == '0) ? PTR_W'(DEPTH - 1) : wp - PTR_W'(1);
    assign top_c  = mem[wp_dec];
    assign do_pop = pop && !push && !empty;

    always_comb begin
        wp_d  = wp;
        cnt_d = cnt;
        if (push) begin
            wp_d  = wp_inc;
            cnt_d = full ? cnt : cnt + CNT_W'(1);
        end else if (do_pop) begin
            wp_d  = wp_dec;
            cnt_d = cnt - CNT_W'(1);
        end
    end

    // Flags derive from the next count so they always agree with cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp    <= wp_d;
            cnt   <= cnt_d;
            full  <= (cnt_d == CNT_W'(DEPTH));
            empty <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= din;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage PC sequencer with branch, call/return and RAS error tracking.
// Optional breakpoint comparator enabled by defining PC_BREAKPOINT_EN.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     STEP      = 1,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             load,
    input  logic                             br,
    input  logic                             call,
    input  logic                             ret,
    input  logic [WIDTH-1:0]                 tgt,
    input  logic [WIDTH-1:0]                 br_off,
    output logic [WIDTH-1:0]                 pc_out,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0]  ras_cnt,
    output logic                             ras_empty,
    output logic                             ras_full,
    output logic                             ras_err
`ifdef PC_BREAKPOINT_EN
    ,
    input  logic                             bp_wr,
    input  logic [WIDTH-1:0]                 bp_addr,
    output logic                             bp_hit
`endif
);

    act_t             act;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] ras_top_c;
    logic             err_d;
    logic             push;
    logic             pop;

    assign ret_addr = pc_out + WIDTH'(STEP);

    // Priority encoder: exactly one action per cycle, lower requests dropped.
    always_comb begin
        act = ACT_NONE;
        if (ret)       act = ACT_RET;
        else if (call) act = ACT_CALL;
        else if (load) act = ACT_LOAD;
        else if (br)   act = ACT_BR;
        else if (en)   act = ACT_EN;
    end

    always_comb begin
        pc_d  = pc_out;
        err_d = ras_err;
        push  = 1'b0;
        pop   = 1'b0;
        case (act)
            ACT_EN:   pc_d = pc_out + WIDTH'(STEP);
            ACT_BR:   pc_d = pc_out + br_off;
            ACT_LOAD: pc_d = tgt;
            ACT_CALL: begin
                push = 1'b1;
                pc_d = tgt;
                if (ras_full) err_d = 1'b1;
            end
            ACT_RET: begin
                if (ras_empty) begin
                    err_d = 1'b1;
                end else begin
                    pop  = 1'b1;
                    pc_d = ras_top_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out  <= RESET_VEC;
            ras_err <= 1'b0;
        end else begin
            pc_out  <= pc_d;
            ras_err <= err_d;
        end
    end

    ret_addr_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .top_c (ras_top_c),
        .cnt   (ras_cnt),
        .full  (ras_full),
        .empty (ras_empty)
    );

`ifdef PC_BREAKPOINT_EN
    logic [WIDTH-1:0] bp_q;
    logic             bp_arm;

    // A hit disarms; a same-cycle bp_wr re-arms with the new address.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_q   <= '0;
            bp_arm <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            bp_hit <= bp_arm && (pc_out == bp_q);
            if (bp_wr) begin
                bp_q   <= bp_addr;
                bp_arm <= 1'b1;
            end else if (bp_arm && (pc_out == bp_q)) begin
                bp_arm <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst, en, load, br, call, ret;
    logic [15:0] tgt, br_off;
    logic [15:0] pc_out;
    logic [2:0]  ras_cnt;
    logic        ras_empty, ras_full, ras_err;
`ifdef PC_BREAKPOINT_EN
    logic        bp_wr = 1'b0;
    logic [15:0] bp_addr = '0;
    logic        bp_hit;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_seq_unit #(
        .WIDTH     (16),
        .STEP      (1),
        .RAS_DEPTH (4),
        .RESET_VEC (16'h0100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .br        (br),
        .call      (call),
        .ret       (ret),
        .tgt       (tgt),
        .br_off    (br_off),
        .pc_out    (pc_out),
        .ras_cnt   (ras_cnt),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
`ifdef PC_BREAKPOINT_EN
        ,
        .bp_wr     (bp_wr),
        .bp_addr   (bp_addr),
        .bp_hit    (bp_hit)
`endif
    );

    // Reference model: PC plus a bounded queue of return addresses.
    logic [15:0] m_pc;
    logic [15:0] m_ras[$];
    logic        m_err;
    bit          m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc    = 16'h0100;
            m_ras   = {};
            m_err   = 1'b0;
            m_valid = 1;
        end else if (m_valid) begin
            if (ret) begin
                if (m_ras.size() == 0) m_err = 1'b1;
                else m_pc = m_ras.pop_back();
            end else if (call) begin
                m_ras.push_back(m_pc + 16'd1);
                if (m_ras.size() > 4) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_pc = tgt;
            end else if (load) m_pc = tgt;
            else if (br)       m_pc = m_pc + br_off;
            else if (en)       m_pc = m_pc + 16'd1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid && !rst) begin
            check("model_pc",    32'(pc_out),    32'(m_pc));
            check("model_cnt",   32'(ras_cnt),   32'(m_ras.size()));
            check("model_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            check("model_full",  32'(ras_full),  32'(m_ras.size() == 4));
            check("model_err",   32'(ras_err),   32'(m_err));
        end
    end

    task automatic step(input logic r, input logic c, input logic l, input logic b,
                        input logic e, input logic [15:0] t, input logic [15:0] o);
        ret = r; call = c; load = l; br = b; en = e; tgt = t; br_off = o;
        @(posedge clk);
        #1;
        ret = 0; call = 0; load = 0; br = 0; en = 0;
    endtask

    task automatic do_en();                 step(0,0,0,0,1,16'h0,16'h0); endtask
    task automatic do_load(input logic [15:0] t); step(0,0,1,0,0,t,16'h0); endtask
    task automatic do_call(input logic [15:0] t); step(0,1,0,0,0,t,16'h0); endtask
    task automatic do_ret();                step(1,0,0,0,0,16'h0,16'h0); endtask

    initial begin
        rst = 1; en = 0; load = 0; br = 0; call = 0; ret = 0; tgt = '0; br_off = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("rst_pc",    32'(pc_out),    32'h0100);
        check("rst_cnt",   32'(ras_cnt),   32'd0);
        check("rst_empty", 32'(ras_empty), 32'd1);
        check("rst_full",  32'(ras_full),  32'd0);
        check("rst_err",   32'(ras_err),   32'd0);

        do_en(); check("en1", 32'(pc_out), 32'h0101);
        do_en(); check("en2", 32'(pc_out), 32'h0102);
        do_en(); check("en3", 32'(pc_out), 32'h0103);
        check("en_empty", 32'(ras_empty), 32'd1);

        do_load(16'hFFFF); do_en(); check("wrap_en", 32'(pc_out), 32'h0000);
        do_load(16'h0010); step(0,0,0,1,0,16'h0,16'hFFF0);
        check("br_neg", 32'(pc_out), 32'h0000);

        // Nested call/return.
        do_load(16'h0020);
        do_call(16'h0200); check("call1_cnt", 32'(ras_cnt), 32'd1);
        do_call(16'h0300); check("call2_cnt", 32'(ras_cnt), 32'd2);
        check("call2_pc", 32'(pc_out), 32'h0300);
        do_ret(); check("ret1_pc", 32'(pc_out), 32'h0201); check("ret1_cnt", 32'(ras_cnt), 32'd1);
        do_ret(); check("ret2_pc", 32'(pc_out), 32'h0021); check("ret2_cnt", 32'(ras_cnt), 32'd0);
        check("nest_err", 32'(ras_err), 32'd0);

        // Overflow: five calls, oldest return address (0x1001) is lost.
        do_load(16'h1000);
        for (int i = 0; i < 5; i++) do_call(16'h2000 + 16'(i * 16));
        check("ovf_full", 32'(ras_full), 32'd1);
        check("ovf_err",  32'(ras_err),  32'd1);
        check("ovf_cnt",  32'(ras_cnt),  32'd4);
        do_ret(); check("pop1", 32'(pc_out), 32'h2031);
        do_ret(); check("pop2", 32'(pc_out), 32'h2021);
        do_ret(); check("pop3", 32'(pc_out), 32'h2011);
        do_ret(); check("pop4", 32'(pc_out), 32'h2001);
        do_ret(); check("udf_pc", 32'(pc_out), 32'h2001);
        check("udf_cnt", 32'(ras_cnt), 32'd0);

        // Simultaneous commands.
        do_load(16'h0040); do_call(16'h0300);
        step(1,1,1,0,1,16'h0700,16'h0);
        check("multi_ret_pc",  32'(pc_out),  32'h0041);
        check("multi_ret_cnt", 32'(ras_cnt), 32'd0);
        step(0,0,1,1,1,16'h0500,16'h0004);
        check("multi_load_pc", 32'(pc_out), 32'h0500);

        // Reset beats a same-cycle call.
        do_call(16'h0600);
        rst = 1; step(0,1,0,0,0,16'h0700,16'h0); rst = 0;
        check("rstcall_pc",  32'(pc_out),  32'h0100);
        check("rstcall_cnt", 32'(ras_cnt), 32'd0);
        check("rstcall_err", 32'(ras_err), 32'd0);
        do_ret();
        check("rstcall_nopush_pc",  32'(pc_out),  32'h0100);
        check("rstcall_nopush_err", 32'(ras_err), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
